div_share_ctrl: RTL and testbench

//  Sequences and shares one iterative divider (signed/unsigned DIV.W/MOD.W/DIV.WU/MOD.WU) between two

---
 rtl/div_share_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_div_share_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : div_share_ctrl
//  Description : Shares one iterative divider between two execute pipes.
//                Fixed-priority grant (pipe 0 older), single start pulse per
//                instruction, result held until the owner acks, flush with
//                drain of the non-abortable divider, and a one-entry
//                quotient/remainder buffer for DIV/MOD pairs.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_share_ctrl #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  input  logic [1:0]             req_signed,
  input  logic [1:0]             req_is_mod,
  input  logic [1:0][DATA_W-1:0] req_dividend,
  input  logic [1:0][DATA_W-1:0] req_divisor,
  input  logic [1:0][TAG_W-1:0]  req_tag,
  input  logic [1:0]             req_ack,
  input  logic [1:0]             flush,
  output logic                   div_start,
  output logic                   div_op,
  output logic [DATA_W-1:0]      div_dividend,
  output logic [DATA_W-1:0]      div_divisor,
  input  logic                   div_busy,
  input  logic                   div_done,
  input  logic [DATA_W-1:0]      div_quotient,
  input  logic [DATA_W-1:0]      div_remainder,
  output logic [1:0]             pause,
  output logic [1:0]             resp_valid,
  output logic [DATA_W-1:0]      resp_data,
  output logic [TAG_W-1:0]       resp_tag
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nx;

  // Latched copy of the granted request
  logic                owner;
  logic                op_signed;
  logic                op_is_mod;
  logic [DATA_W-1:0]   op_dividend;
  logic [DATA_W-1:0]   op_divisor;
  logic [TAG_W-1:0]    op_tag;

  // One-entry result buffer
  logic                buf_valid;
  logic                buf_signed;
  logic [DATA_W-1:0]   buf_dividend;
  logic [DATA_W-1:0]   buf_divisor;
  logic [DATA_W-1:0]   buf_quot;
  logic [DATA_W-1:0]   buf_rem;

  logic [1:0]          eligible;
  logic                grant_any;
  logic                grant_sel;
  logic                buf_hit;
  logic                take;
  logic                fill;
  logic                hold;

  // Arbitration and buffer lookup for the candidate request
  always_comb begin
    eligible  = req_valid & ~flush;
    grant_sel = ~eligible[0];
    grant_any = (|eligible) & ~div_busy;
    buf_hit   = buf_valid
              && (buf_dividend == req_dividend[grant_sel])
              && (buf_divisor  == req_divisor[grant_sel])
              && (buf_signed   == req_signed[grant_sel]);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Next-state logic, start pulse and capture strobes
  always_comb begin
    state_nx  = state;
    div_start = 1'b0;
    take      = 1'b0;
    fill      = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant_any) begin
          take     = 1'b1;
          state_nx = buf_hit ? S_HOLD : S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A divider still running blocks the start; a flush before the start
        // then needs no drain.
        if (!div_busy) begin
          div_start = 1'b1;
          state_nx  = flush[owner] ? S_DRAIN : S_WAIT;
        end else if (flush[owner]) begin
          state_nx = S_IDLE;
        end
      end
      S_WAIT: begin
        if (div_done) begin
          fill     = 1'b1;
          state_nx = flush[owner] ? S_IDLE : S_HOLD;
        end else if (flush[owner]) begin
          state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (div_done) begin
          fill     = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_HOLD: begin
        if (req_ack[owner] || flush[owner]) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Request latch on grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner       <= 1'b0;
      op_signed   <= 1'b0;
      op_is_mod   <= 1'b0;
      op_dividend <= '0;
      op_divisor  <= '0;
      op_tag      <= '0;
    end else if (take) begin
      owner       <= grant_sel;
      op_signed   <= req_signed[grant_sel];
      op_is_mod   <= req_is_mod[grant_sel];
      op_dividend <= req_dividend[grant_sel];
      op_divisor  <= req_divisor[grant_sel];
      op_tag      <= req_tag[grant_sel];
    end
  end

  // Result buffer fill on every completed divide, including drained ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid    <= 1'b0;
      buf_signed   <= 1'b0;
      buf_dividend <= '0;
      buf_divisor  <= '0;
      buf_quot     <= '0;
      buf_rem      <= '0;
    end else if (fill) begin
      buf_valid    <= 1'b1;
      buf_signed   <= op_signed;
      buf_dividend <= op_dividend;
      buf_divisor  <= op_divisor;
      buf_quot     <= div_quotient;
      buf_rem      <= div_remainder;
    end
  end

  // In HOLD the buffer always matches the latched operands (hit or fresh fill),
  // so the response is read from it in both cases.
  assign hold         = (state == S_HOLD);
  assign resp_valid   = hold ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign resp_data    = hold ? (op_is_mod ? buf_rem : buf_quot) : '0;
  assign resp_tag     = hold ? op_tag : '0;
  assign pause        = req_valid & ~resp_valid;
  assign div_op       = op_signed;
  assign div_dividend = op_dividend;
  assign div_divisor  = op_divisor;

endmodule
`default_nettype wire

// File: tb/tb_div_share_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
module tb_div_share_ctrl;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 32;
  localparam int LAT    = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0]             req_valid, req_signed, req_is_mod, req_ack, flush;
  logic [1:0][DATA_W-1:0] req_dividend, req_divisor;
  logic [1:0][TAG_W-1:0]  req_tag;
  logic                   div_start, div_op;
  logic [DATA_W-1:0]      div_dividend, div_divisor;
  logic                   div_busy, div_done;
  logic [DATA_W-1:0]      div_quotient, div_remainder;
  logic [1:0]             pause, resp_valid;
  logic [DATA_W-1:0]      resp_data;
  logic [TAG_W-1:0]       resp_tag;

  div_share_ctrl #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_signed(req_signed), .req_is_mod(req_is_mod),
    .req_dividend(req_dividend), .req_divisor(req_divisor), .req_tag(req_tag),
    .req_ack(req_ack), .flush(flush),
    .div_start(div_start), .div_op(div_op),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_busy(div_busy), .div_done(div_done),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .pause(pause), .resp_valid(resp_valid), .resp_data(resp_data), .resp_tag(resp_tag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural iterative divider with fixed latency
  int                dcnt;
  logic [DATA_W-1:0] m_a, m_b;
  logic              m_s;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_busy <= 1'b0; div_done <= 1'b0; dcnt <= 0;
      div_quotient <= '0; div_remainder <= '0;
      m_a <= '0; m_b <= '0; m_s <= 1'b0;
    end else begin
      div_done <= 1'b0;
      if (div_start) begin
        div_busy <= 1'b1; dcnt <= LAT;
        m_a <= div_dividend; m_b <= div_divisor; m_s <= div_op;
      end else if (div_busy) begin
        if (dcnt == 1) begin
          div_busy <= 1'b0; div_done <= 1'b1;
          if (m_s) begin
            div_quotient  <= $signed(m_a) / $signed(m_b);
            div_remainder <= $signed(m_a) % $signed(m_b);
          end else begin
            div_quotient  <= m_a / m_b;
            div_remainder <= m_a % m_b;
          end
        end
        dcnt <= dcnt - 1;
      end
    end
  end

  // Cycle bookkeeping plus divider-interface protocol checks
  int cyc = 0, n_start = 0, start_cyc = -1, done_cyc = -1;
  always @(posedge clk) begin
    cyc++;
    if (div_start) begin n_start++; start_cyc = cyc; end
    if (div_done) done_cyc = cyc;
    if (rst && div_start) begin
      checks++;
      if (div_busy !== 1'b0) begin errors++; $display("FAIL start_while_busy: busy %b required 0", div_busy); end
    end
    if (rst && div_busy && !div_start) begin
      checks++;
      if (div_dividend !== m_a || div_divisor !== m_b) begin
        errors++; $display("FAIL operand_stable: got %h/%h required %h/%h", div_dividend, div_divisor, m_a, m_b);
      end
    end
  end

  typedef struct packed {
    logic              pipe;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } exp_t;
  exp_t sb[$];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_req(input int p, input bit s, input bit m,
                           input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                           input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] exp_data);
    exp_t e;
    req_signed[p] = s; req_is_mod[p] = m;
    req_dividend[p] = a; req_divisor[p] = b; req_tag[p] = t;
    req_valid[p] = 1'b1;
    e.pipe = p[0]; e.data = exp_data; e.tag = t;
    sb.push_back(e);
  endtask

  task automatic wait_resp(input int p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (resp_valid[p]) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pop_exp(output exp_t e);
    if (sb.size() > 0) e = sb.pop_front();
    else e = '0;
  endtask

  task automatic ack(input int p);
    req_ack[p] = 1'b1;
    tick();
    req_ack[p] = 1'b0; req_valid[p] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    req_valid = '0; req_signed = '0; req_is_mod = '0; req_ack = '0; flush = '0;
    req_dividend = '0; req_divisor = '0; req_tag = '0;
    rst = 1'b0;
    tick(); tick();
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid: got %b required 00", resp_valid); end
    checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL reset_div_start: got %b required 0", div_start); end
    checks++; if (resp_data !== '0 || resp_tag !== '0) begin errors++; $display("FAIL reset_resp: got %h/%h required 0/0", resp_data, resp_tag); end
    checks++; if (pause !== 2'b00) begin errors++; $display("FAIL reset_pause: got %b required 00", pause); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_miss();
    int s0, rc; bit ok; exp_t e;
    s0 = n_start; rc = cyc;
    drive_req(0, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h100, 32'hFFFF_FFFD);
    tick();
    checks++; if (pause[0] !== 1'b1) begin errors++; $display("FAIL single_pause_busy: got %b required 1", pause[0]); end
    wait_resp(0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got no response required resp_valid[0]"); end
    checks++; if (n_start - s0 != 1) begin errors++; $display("FAIL single_starts: got %0d required 1", n_start - s0); end
    checks++; if (start_cyc != rc + 2) begin errors++; $display("FAIL single_start_cycle: got %0d required %0d", start_cyc, rc + 2); end
    checks++; if (cyc != done_cyc) begin errors++; $display("FAIL single_resp_latency: got %0d required %0d", cyc, done_cyc); end
    checks++; if (pause[0] !== 1'b0) begin errors++; $display("FAIL single_pause_done: got %b required 0", pause[0]); end
    pop_exp(e);
    checks++; if (resp_data !== e.data || resp_tag !== e.tag || resp_valid !== 2'b01) begin
      errors++; $display("FAIL single_result: got %h/%h/%b required %h/%h/01", resp_data, resp_tag, resp_valid, e.data, e.tag); end
    ack(0);
  endtask

  task automatic test_priority();
    int a; bit ok; exp_t e;
    drive_req(0, 1'b1, 1'b0, 32'd20, 32'd3, 32'h200, 32'd6);
    drive_req(1, 1'b0, 1'b1, 32'd9,  32'd4, 32'h204, 32'd1);
    wait_resp(0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL prio_timeout0: got no response required resp_valid[0]"); end
    checks++; if (resp_valid !== 2'b01 || pause[1] !== 1'b1) begin
      errors++; $display("FAIL prio_order: got resp %b pause1 %b required 01/1", resp_valid, pause[1]); end
    pop_exp(e);
    checks++; if (resp_data !== e.data || resp_tag !== e.tag) begin
      errors++; $display("FAIL prio_result0: got %h/%h required %h/%h", resp_data, resp_tag, e.data, e.tag); end
    a = cyc + 1;
    ack(0);
    wait_resp(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL prio_timeout1: got no response required resp_valid[1]"); end
    checks++; if (start_cyc != a + 2) begin errors++; $display("FAIL prio_start1_cycle: got %0d required %0d", start_cyc, a + 2); end
    pop_exp(e);
    checks++; if (resp_data !== e.data || resp_tag !== e.tag || resp_valid !== 2'b10) begin
      errors++; $display("FAIL prio_result1: got %h/%h/%b required %h/%h/10", resp_data, resp_tag, resp_valid, e.data, e.tag); end
    ack(1);
  endtask

  task automatic test_buffer_hit();
    int s0, rc; bit ok; exp_t e;
    drive_req(0, 1'b0, 1'b0, 32'd100, 32'd7, 32'h300, 32'd14);
    wait_resp(0, ok);
    pop_exp(e);
    checks++; if (!ok || resp_data !== e.data) begin errors++; $display("FAIL hit_first_div: got %h required %h", resp_data, e.data); end
    ack(0);
    s0 = n_start; rc = cyc;
    drive_req(0, 1'b0, 1'b1, 32'd100, 32'd7, 32'h304, 32'd2);
    wait_resp(0, ok);
    checks++; if (!ok || cyc != rc + 1) begin errors++; $display("FAIL hit_latency: got %0d required %0d", cyc, rc + 1); end
    checks++; if (n_start != s0) begin errors++; $display("FAIL hit_no_start: got %0d starts required 0", n_start - s0); end
    pop_exp(e);
    checks++; if (resp_data !== e.data || resp_tag !== e.tag) begin
      errors++; $display("FAIL hit_result: got %h/%h required %h/%h", resp_data, resp_tag, e.data, e.tag); end
    ack(0);
  endtask

  task automatic test_flush_drain();
    int s0, rc, seen; bit ok; exp_t e;
    s0 = n_start;
    req_signed[0] = 1'b1; req_is_mod[0] = 1'b0;
    req_dividend[0] = 32'hFFFF_FFF9; req_divisor[0] = 32'd2; req_tag[0] = 32'h400;
    req_valid[0] = 1'b1;
    tick(); tick(); tick(); tick();
    flush[0] = 1'b1;
    tick();
    flush[0] = 1'b0; req_valid[0] = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid !== 2'b00) seen++;
      tick();
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_resp: got %0d cycles required 0", seen); end
    checks++; if (n_start - s0 != 1) begin errors++; $display("FAIL flush_starts: got %0d required 1", n_start - s0); end
    s0 = n_start; rc = cyc;
    drive_req(1, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'h404, 32'hFFFF_FFFF);
    wait_resp(1, ok);
    checks++; if (!ok || cyc != rc + 1 || n_start != s0) begin
      errors++; $display("FAIL flush_hit: got cyc %0d starts %0d required %0d/0", cyc, n_start - s0, rc + 1); end
    pop_exp(e);
    checks++; if (resp_data !== e.data || resp_tag !== e.tag) begin
      errors++; $display("FAIL flush_hit_result: got %h/%h required %h/%h", resp_data, resp_tag, e.data, e.tag); end
    ack(1);
  endtask

  task automatic test_reset_mid_wait();
    int s0, rc; bit ok; exp_t e;
    drive_req(0, 1'b1, 1'b0, 32'd55, 32'd5, 32'h500, 32'd11);
    wait_resp(0, ok);
    pop_exp(e);
    checks++; if (!ok || resp_data !== e.data) begin errors++; $display("FAIL rst_prefill: got %h required %h", resp_data, e.data); end
    ack(0);
    req_signed[0] = 1'b0; req_is_mod[0] = 1'b0;
    req_dividend[0] = 32'd8; req_divisor[0] = 32'd2; req_tag[0] = 32'h504;
    req_valid[0] = 1'b1;
    tick(); tick(); tick();
    #2;
    rst = 1'b0; req_valid = '0;
    #1;
    checks++; if (resp_valid !== 2'b00 || div_start !== 1'b0 || pause !== 2'b00) begin
      errors++; $display("FAIL rst_async_ctrl: got %b/%b/%b required 00/0/00", resp_valid, div_start, pause); end
    checks++; if (div_dividend !== '0 || div_divisor !== '0 || div_op !== 1'b0 || resp_data !== '0 || resp_tag !== '0) begin
      errors++; $display("FAIL rst_async_data: got %h/%h/%b/%h/%h required zeros", div_dividend, div_divisor, div_op, resp_data, resp_tag); end
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    s0 = n_start; rc = cyc;
    drive_req(0, 1'b1, 1'b0, 32'd55, 32'd5, 32'h508, 32'd11);
    wait_resp(0, ok);
    checks++; if (!ok || n_start - s0 != 1 || start_cyc != rc + 2) begin
      errors++; $display("FAIL rst_buffer_cleared: got starts %0d at %0d required 1 at %0d", n_start - s0, start_cyc, rc + 2); end
    pop_exp(e);
    checks++; if (resp_data !== e.data || resp_tag !== e.tag) begin
      errors++; $display("FAIL rst_result: got %h/%h required %h/%h", resp_data, resp_tag, e.data, e.tag); end
    ack(0);
  endtask

  task automatic test_hold_stable();
    int s0, bad; bit ok; exp_t e;
    drive_req(1, 1'b0, 1'b0, 32'd1000, 32'd10, 32'h600, 32'd100);
    wait_resp(1, ok);
    pop_exp(e);
    checks++; if (!ok || resp_data !== e.data || resp_tag !== e.tag) begin
      errors++; $display("FAIL hold_result: got %h/%h required %h/%h", resp_data, resp_tag, e.data, e.tag); end
    s0 = n_start; bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (resp_valid !== 2'b10 || resp_data !== e.data || resp_tag !== e.tag) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL hold_stable: got %0d unstable cycles required 0", bad); end
    checks++; if (n_start != s0) begin errors++; $display("FAIL hold_no_start: got %0d starts required 0", n_start - s0); end
    ack(1);
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL hold_release: got %b required 00", resp_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_miss();
    test_priority();
    test_buffer_hit();
    test_flush_drain();
    test_reset_mid_wait();
    test_hold_stable();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drained: got %0d left required 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
